// File: rtl/cpu_dbg_pkg.sv
// Shared types for the CPU debug monitor: halt FSM states and trace entry layout.
package cpu_dbg_pkg;

  // Halt control: the CPU either runs freely or is frozen by the debug button.
  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } halt_state_t;

  // Default widths, used by the reference entry layout below.
  localparam int DEF_DATA_W = 32;
  localparam int DEF_PC_W   = 32;
  localparam int DEF_AW     = 3;

  // Reference layout of one trace entry (MSB to LSB: pc, register index, data).
  // The monitor packs entries in this order for any width configuration.
  typedef struct packed {
    logic [DEF_PC_W-1:0]   pc;
    logic [DEF_AW-1:0]     idx;
    logic [DEF_DATA_W-1:0] data;
  } trace_entry_t;

  // Width of a packed trace entry for an arbitrary configuration.
  function automatic int trace_entry_w(input int pc_w, input int aw, input int data_w);
    return pc_w + aw + data_w;
  endfunction

endpackage

// File: rtl/cpu_trace_fifo.sv
// Circular trace buffer: head-of-queue read, separate occupancy count,
// sticky overflow, and selectable overwrite-oldest / drop-newest on full.
module cpu_trace_fifo #(
  parameter  int DEPTH   = 16,
  parameter  int ENTRY_W = 67,
  parameter  int WRAP    = 1,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop_ready,
  output logic               rd_valid,
  output logic [ENTRY_W-1:0] rd_entry,
  output logic [CW-1:0]      count,
  output logic               overflow
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          overflow_reg, overflow_next;
  logic          do_write;
  logic          full, empty, pop;

  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);
  // A pop needs something to pop; ready while empty is simply ignored.
  assign pop   = !empty && pop_ready;

  // Next-state: pointers, occupancy, overflow and whether the slot at wr_ptr is written.
  always_comb begin
    do_write      = 1'b0;
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;
    if (push && full && !pop) begin
      // No room and nothing leaving: either overwrite the oldest slot
      // (both pointers slide, count stays at DEPTH) or drop the new entry.
      overflow_next = 1'b1;
      if (WRAP != 0) begin
        do_write    = 1'b1;
        wr_ptr_next = wr_ptr_reg + 1'b1;
        rd_ptr_next = rd_ptr_reg + 1'b1;
      end
    end else begin
      if (push) begin
        do_write    = 1'b1;
        wr_ptr_next = wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + 1'b1;
      end
      if (push && !pop) begin
        count_next = count_reg + 1'b1;
      end else if (!push && pop) begin
        count_next = count_reg - 1'b1;
      end
    end
  end

  // Control state register; reset discards the buffer by clearing pointers and count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end

  // Entry storage; contents need no reset because the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  assign rd_valid = !empty;
  assign rd_entry = empty ? '0 : mem[rd_ptr_reg];
  assign count    = count_reg;
  assign overflow = overflow_reg;

endmodule

// File: rtl/cpu_trace_monitor.sv
// Debug monitor beside the CPU: captures register-file writes into a trace
// buffer, keeps a shadow register file, and toggles cpu_halt from a button.
module cpu_trace_monitor
  import cpu_dbg_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int PC_W   = 32,
  parameter  int NREGS  = 8,
  parameter  int DEPTH  = 16,
  parameter  int WRAP   = 1,
  localparam int AW     = $clog2(NREGS),
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt_button,
  input  logic [PC_W-1:0]   pc,
  input  logic              rf_we,
  input  logic [AW-1:0]     rf_waddr,
  input  logic [DATA_W-1:0] rf_wdata,
  output logic              cpu_halt,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [PC_W-1:0]   rd_pc,
  output logic [AW-1:0]     rd_reg,
  output logic [DATA_W-1:0] rd_data,
  output logic [CW-1:0]     count,
  output logic              overflow,
  input  logic [AW-1:0]     shadow_sel,
  output logic [DATA_W-1:0] shadow_data
);

  localparam int ENTRY_W = trace_entry_w(PC_W, AW, DATA_W);

  logic        sync1_reg, sync2_reg, prev_reg;
  logic        button_rise;
  halt_state_t state_reg, state_next;
  logic        push;
  logic [ENTRY_W-1:0] push_entry, rd_entry;
  logic [DATA_W-1:0]  shadow_reg [NREGS];

  // Two-flop synchroniser for the raw button plus a delayed copy for edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      prev_reg  <= 1'b0;
    end else begin
      sync1_reg <= halt_button;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  // Only a fresh press toggles; a held button produces a single rise.
  assign button_rise = sync2_reg && !prev_reg;

  // Halt FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Halt FSM next state and output: each button rise flips RUN <-> HALTED.
  always_comb begin
    state_next = state_reg;
    cpu_halt   = 1'b0;
    case (state_reg)
      RUN: begin
        if (button_rise) state_next = HALTED;
      end
      HALTED: begin
        cpu_halt = 1'b1;
        if (button_rise) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  // The trace only records writes the CPU makes while running.
  assign push       = rf_we && (state_reg == RUN);
  assign push_entry = {pc, rf_waddr, rf_wdata};

  cpu_trace_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W),
    .WRAP    (WRAP)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop_ready (rd_ready),
    .rd_valid  (rd_valid),
    .rd_entry  (rd_entry),
    .count     (count),
    .overflow  (overflow)
  );

  assign rd_pc   = rd_entry[ENTRY_W-1 -: PC_W];
  assign rd_reg  = rd_entry[DATA_W +: AW];
  assign rd_data = rd_entry[DATA_W-1:0];

  // Shadow register file: mirrors every register write, running or halted.
  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_shadow
      // One register per architectural index, loaded when the CPU writes it.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          shadow_reg[gi] <= '0;
        end else if (rf_we && (rf_waddr == AW'(gi))) begin
          shadow_reg[gi] <= rf_wdata;
        end
      end
    end
  endgenerate

  assign shadow_data = shadow_reg[shadow_sel];

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Self-checking bench: a WRAP=1 and a WRAP=0 monitor share stimulus and are
// compared every cycle against a queue-based model, plus literal spot checks.
module tb_cpu_trace_monitor;

  localparam int DATA_W = 32;
  localparam int PC_W   = 32;
  localparam int NREGS  = 8;
  localparam int DEPTH  = 16;
  localparam int AW     = 3;
  localparam int CW     = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              halt_button = 1'b0;
  logic [PC_W-1:0]   pc = '0;
  logic              rf_we = 1'b0;
  logic [AW-1:0]     rf_waddr = '0;
  logic [DATA_W-1:0] rf_wdata = '0;
  logic              rd_ready = 1'b0;
  logic [AW-1:0]     shadow_sel = '0;

  logic              halt_w, halt_d, valid_w, valid_d, ovf_w, ovf_d;
  logic [PC_W-1:0]   rpc_w, rpc_d;
  logic [AW-1:0]     rreg_w, rreg_d;
  logic [DATA_W-1:0] rdata_w, rdata_d, sh_w, sh_d;
  logic [CW-1:0]     cnt_w, cnt_d;

  int checks = 0;
  int errors = 0;
  bit run_cmp = 1'b0;

  always #5 clk = ~clk;

  cpu_trace_monitor #(.DATA_W(DATA_W), .PC_W(PC_W), .NREGS(NREGS), .DEPTH(DEPTH), .WRAP(1)) dut_w (
    .clk(clk), .rst(rst), .halt_button(halt_button), .pc(pc), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .cpu_halt(halt_w), .rd_valid(valid_w),
    .rd_ready(rd_ready), .rd_pc(rpc_w), .rd_reg(rreg_w), .rd_data(rdata_w),
    .count(cnt_w), .overflow(ovf_w), .shadow_sel(shadow_sel), .shadow_data(sh_w)
  );

  cpu_trace_monitor #(.DATA_W(DATA_W), .PC_W(PC_W), .NREGS(NREGS), .DEPTH(DEPTH), .WRAP(0)) dut_d (
    .clk(clk), .rst(rst), .halt_button(halt_button), .pc(pc), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .cpu_halt(halt_d), .rd_valid(valid_d),
    .rd_ready(rd_ready), .rd_pc(rpc_d), .rd_reg(rreg_d), .rd_data(rdata_d),
    .count(cnt_d), .overflow(ovf_d), .shadow_sel(shadow_sel), .shadow_data(sh_d)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [PC_W-1:0]   pc;
    logic [AW-1:0]     idx;
    logic [DATA_W-1:0] data;
  } m_entry_t;

  m_entry_t          qw[$];
  m_entry_t          qd[$];
  bit                m_ovf_w, m_ovf_d;
  bit                m_halt, m_last_btn;
  bit                rise_q[$];
  logic [DATA_W-1:0] m_shadow [NREGS];

  task automatic model_reset();
    qw.delete();
    qd.delete();
    m_ovf_w = 1'b0;
    m_ovf_d = 1'b0;
    m_halt = 1'b0;
    m_last_btn = 1'b0;
    rise_q.delete();
    for (int i = 0; i < NREGS; i++) m_shadow[i] = '0;
  endtask

  task automatic model_step();
    bit halted_before, pushm, popw, popd;
    m_entry_t e;
    halted_before = m_halt;
    // A press sampled at edge k takes effect after edge k+2.
    rise_q.push_back(halt_button && !m_last_btn);
    m_last_btn = halt_button;
    if (rise_q.size() >= 3) m_halt = m_halt ^ rise_q[rise_q.size() - 3];
    pushm = rf_we && !halted_before;
    e.pc = pc;
    e.idx = rf_waddr;
    e.data = rf_wdata;
    if (rf_we) m_shadow[rf_waddr] = rf_wdata;
    popw = (qw.size() != 0) && rd_ready;
    popd = (qd.size() != 0) && rd_ready;
    if (pushm && qw.size() == DEPTH && !popw) begin
      qw.delete(0);
      qw.push_back(e);
      m_ovf_w = 1'b1;
    end else begin
      if (popw) qw.delete(0);
      if (pushm) qw.push_back(e);
    end
    if (pushm && qd.size() == DEPTH && !popd) begin
      m_ovf_d = 1'b1;
    end else begin
      if (popd) qd.delete(0);
      if (pushm) qd.push_back(e);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else model_step();
  end

  // ---------------- per-cycle compare ----------------
  task automatic compare_all();
    check("w_halt", halt_w, m_halt);
    check("d_halt", halt_d, m_halt);
    check("w_count", cnt_w, qw.size());
    check("d_count", cnt_d, qd.size());
    check("w_valid", valid_w, qw.size() != 0);
    check("d_valid", valid_d, qd.size() != 0);
    check("w_ovf", ovf_w, m_ovf_w);
    check("d_ovf", ovf_d, m_ovf_d);
    check("w_rd_pc", rpc_w, qw.size() != 0 ? qw[0].pc : '0);
    check("w_rd_reg", rreg_w, qw.size() != 0 ? qw[0].idx : '0);
    check("w_rd_data", rdata_w, qw.size() != 0 ? qw[0].data : '0);
    check("d_rd_pc", rpc_d, qd.size() != 0 ? qd[0].pc : '0);
    check("d_rd_reg", rreg_d, qd.size() != 0 ? qd[0].idx : '0);
    check("d_rd_data", rdata_d, qd.size() != 0 ? qd[0].data : '0);
    check("w_shadow", sh_w, m_shadow[shadow_sel]);
    check("d_shadow", sh_d, m_shadow[shadow_sel]);
  endtask

  always @(negedge clk) begin
    if (run_cmp && !rst) compare_all();
  end

  // Hard time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [PC_W-1:0] p, input logic [AW-1:0] a, input logic [DATA_W-1:0] d);
    pc = p;
    rf_waddr = a;
    rf_wdata = d;
    rf_we = 1'b1;
    tick();
    rf_we = 1'b0;
  endtask

  task automatic pulse_reset();
    #2;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    run_cmp = 1'b1;
    @(negedge clk);
    check("reset_count", cnt_w, 0);
    check("reset_valid", valid_w, 0);
    check("reset_ovf", ovf_w, 0);
    check("reset_halt", halt_w, 0);
    $display("txn reset: count=%0d valid=%0d", cnt_w, valid_w);

    // Capture one write.
    tick();
    wr(32'h10, 3'd3, 32'h2A);
    shadow_sel = 3'd3;
    @(negedge clk);
    check("cap_valid", valid_w, 1);
    check("cap_pc", rpc_w, 32'h10);
    check("cap_reg", rreg_w, 3);
    check("cap_data", rdata_w, 32'h2A);
    check("cap_count", cnt_w, 1);
    check("cap_shadow", sh_w, 32'h2A);
    $display("txn capture: pc=0x%0h reg=%0d data=0x%0h", rpc_w, rreg_w, rdata_w);
    tick();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;

    // Reset mid-run with five entries held.
    for (int i = 0; i < 5; i++) wr(32'h20 + i, 3'(i), 32'h100 + i);
    @(negedge clk);
    check("pre_rst_count", cnt_w, 5);
    pulse_reset();
    @(negedge clk);
    check("rst_count", cnt_w, 0);
    check("rst_valid", valid_w, 0);
    check("rst_ovf", ovf_w, 0);
    check("rst_halt", halt_w, 0);
    $display("txn midrun_reset: count=%0d", cnt_w);

    // Overfill both flavours with data 1..18.
    tick();
    for (int i = 1; i <= 18; i++) wr(32'h100 + i, 3'(i % 8), 32'(i));
    @(negedge clk);
    check("wrap_count", cnt_w, 16);
    check("wrap_ovf", ovf_w, 1);
    check("drop_count", cnt_d, 16);
    check("drop_ovf", ovf_d, 1);
    tick();
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("wrap_pop", rdata_w, 32'(3 + i));
      check("drop_pop", rdata_d, 32'(1 + i));
      $display("txn pop %0d: wrap=%0d drop=%0d", i, rdata_w, rdata_d);
      tick();
    end
    rd_ready = 1'b0;
    @(negedge clk);
    check("drained_w", cnt_w, 0);
    check("drained_d", cnt_d, 0);
    pulse_reset();

    // Halt toggling.
    wr(32'h40, 3'd5, 32'h77);
    halt_button = 1'b1;
    tick();
    halt_button = 1'b0;
    @(negedge clk);
    check("halt_edge1", halt_w, 0);
    tick();
    @(negedge clk);
    check("halt_edge2", halt_w, 0);
    tick();
    @(negedge clk);
    check("halt_edge3", halt_w, 1);
    $display("txn halt: cpu_halt=%0d", halt_w);
    tick();
    wr(32'h44, 3'd1, 32'h55);
    wr(32'h48, 3'd2, 32'h66);
    shadow_sel = 3'd1;
    @(negedge clk);
    check("halt_shadow", sh_w, 32'h55);
    check("halt_count", cnt_w, 1);
    halt_button = 1'b1;
    tick();
    halt_button = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("resume", halt_w, 0);
    $display("txn resume: cpu_halt=%0d", halt_w);
    halt_button = 1'b1;
    repeat (10) tick();
    halt_button = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    check("held_once", halt_w, 1);
    $display("txn held_button: cpu_halt=%0d", halt_w);
    halt_button = 1'b1;
    tick();
    halt_button = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    check("held_release", halt_w, 0);
    pulse_reset();

    // Full buffer with simultaneous push and pop.
    for (int i = 0; i < 16; i++) wr(32'h300 + i, 3'(i % 8), 32'h200 + i);
    @(negedge clk);
    check("full_count", cnt_w, 16);
    check("full_ovf", ovf_w, 0);
    check("full_head", rdata_w, 32'h200);
    pc = 32'h3FF;
    rf_waddr = 3'd7;
    rf_wdata = 32'h999;
    rf_we = 1'b1;
    rd_ready = 1'b1;
    tick();
    rf_we = 1'b0;
    rd_ready = 1'b0;
    @(negedge clk);
    check("pp_count_w", cnt_w, 16);
    check("pp_count_d", cnt_d, 16);
    check("pp_ovf_w", ovf_w, 0);
    check("pp_ovf_d", ovf_d, 0);
    check("pp_head_w", rdata_w, 32'h201);
    check("pp_head_d", rdata_d, 32'h201);
    $display("txn full_push_pop: count=%0d head=0x%0h", cnt_w, rdata_w);

    // Mixed traffic, checked by the per-cycle model comparison.
    tick();
    for (int i = 0; i < 60; i++) begin
      rf_we = (i % 3) != 0;
      rd_ready = (i % 2 == 0) || (i > 40);
      pc = 32'h500 + i;
      rf_waddr = 3'(i);
      rf_wdata = 32'(i) * 32'h1111;
      shadow_sel = 3'(i + 1);
      tick();
    end
    rf_we = 1'b0;
    rd_ready = 1'b1;
    repeat (20) tick();
    rd_ready = 1'b0;
    @(negedge clk);
    check("mixed_drain_w", cnt_w, 0);
    check("mixed_drain_d", cnt_d, 0);
    $display("txn mixed: ovf_w=%0d ovf_d=%0d", ovf_w, ovf_d);

    run_cmp = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
